// File: rtl/button_event_ctrl_if.sv
// Event handshake bundle between button_event_ctrl and its consumer.
//   evt_valid  : an event is offered (producer -> consumer)
//   evt_id     : index of the offered button (producer -> consumer)
//   evt_repeat : offered event came from auto-repeat (producer -> consumer)
//   evt_ready  : consumer accepts the offered event (consumer -> producer)
interface button_event_ctrl_if #(
    parameter int unsigned N_BTN = 4
);
    localparam int unsigned ID_W = $clog2(N_BTN);

    logic            evt_valid;
    logic [ID_W-1:0] evt_id;
    logic            evt_repeat;
    logic            evt_ready;

    modport master (
        output evt_valid,
        output evt_id,
        output evt_repeat,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        input  evt_repeat,
        output evt_ready
    );
endinterface

// File: rtl/button_event_ctrl.sv
// Button event controller: turns debounced button press edges (and, optionally,
// auto-repeat while held) into a queue of one pending event per button, offered
// one at a time in fixed lowest-index-first priority over a valid/ready link.
//
// Ports:
//   clk       : system clock, all state on rising edge
//   rst       : synchronous active-high reset
//   btn_in    : debounced, clk-synchronous button levels (active-high)
//   evt       : event handshake (master side: valid/id/repeat out, ready in)
//   btn_held  : registered copy of btn_in
//   drop_cnt  : saturating count of events lost to an already-pending button
//
// Build option: define BTN_REPEAT_EN to add the shared auto-repeat counter.
// Without it no counter exists and evt_repeat is constant 0.
module button_event_ctrl #(
    parameter int unsigned N_BTN         = 4,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_BTN-1:0]       btn_in,
    button_event_ctrl_if.master    evt,
    output logic [N_BTN-1:0]       btn_held,
    output logic [7:0]             drop_cnt
);

    localparam int unsigned ID_W    = $clog2(N_BTN);
    localparam int unsigned NDROP_W = 4;
    localparam int unsigned SUM_W   = 10;

    // Elaboration-time configuration sanity check
    if (N_BTN < 2 || N_BTN > 8 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("button_event_ctrl: unsupported parameter set");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [N_BTN-1:0]   pend_q, pend_d;
    logic [N_BTN-1:0]   tag_q, tag_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               rep_q, rep_d;
    logic [7:0]         drop_d;
    logic [NDROP_W-1:0] n_drop;
    logic [SUM_W-1:0]   drop_sum;
    logic [N_BTN-1:0]   rise;
    logic [N_BTN-1:0]   rpt_set;
    logic [ID_W-1:0]    first_pend;
    logic               accept;

    // Lowest set index of a vector (0 when empty)
    function automatic logic [ID_W-1:0] lowest_idx(input logic [N_BTN-1:0] v);
        logic [ID_W-1:0] r;
        logic            found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < int'(N_BTN); i++) begin
            if (v[i] && !found) begin
                r     = ID_W'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign rise       = btn_in & ~btn_held;
    assign accept     = (state_q == OFFER) && evt.evt_ready;
    assign first_pend = lowest_idx(pend_q);

    assign evt.evt_valid  = (state_q == OFFER);
    assign evt.evt_id     = id_q;
    assign evt.evt_repeat = rep_q;

`ifdef BTN_REPEAT_EN
    localparam int unsigned CNT_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
    localparam logic [CNT_W-1:0] FIRST_HIT = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] NEXT_HIT  = CNT_W'(REPEAT_DELAY + REPEAT_PERIOD);

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [ID_W-1:0]  idx_in, idx_held;
    logic             run;

    // Shared repeat counter: counts edges the same lowest-index button stays held.
    // The press edge itself loads 0 because btn_held is still low there.
    always_comb begin
        idx_in   = lowest_idx(btn_in);
        idx_held = lowest_idx(btn_held);
        run      = (|btn_in) && (|btn_held) && (idx_in == idx_held);
        cnt_inc  = cnt_q + CNT_W'(1);
        cnt_d    = '0;
        rpt_set  = '0;
        if (run) begin
            cnt_d = cnt_inc;
            if (cnt_inc == FIRST_HIT) begin
                rpt_set[idx_in] = 1'b1;
            end
            if (cnt_inc == NEXT_HIT) begin
                rpt_set[idx_in] = 1'b1;
                cnt_d           = FIRST_HIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign rpt_set = '0;
`endif

    // Pending/tag update and drop accounting; a same-edge acceptance frees the slot
    always_comb begin
        pend_d = pend_q;
        tag_d  = tag_q;
        n_drop = '0;
        if (accept) begin
            pend_d[id_q] = 1'b0;
        end
        for (int i = 0; i < int'(N_BTN); i++) begin
            if (rise[i] || rpt_set[i]) begin
                if (pend_q[i] && !(accept && (id_q == ID_W'(i)))) begin
                    n_drop = n_drop + NDROP_W'(1);
                end else begin
                    pend_d[i] = 1'b1;
                    tag_d[i]  = rpt_set[i];
                end
            end
        end
        drop_sum = SUM_W'(drop_cnt) + SUM_W'(n_drop);
        drop_d   = (drop_sum > SUM_W'(255)) ? 8'hFF : drop_sum[7:0];
    end

    // Offer FSM: latch id/tag on entry, hold until accepted
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        rep_d   = rep_q;
        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    state_d = OFFER;
                    id_d    = first_pend;
                    rep_d   = tag_q[first_pend];
                end
            end
            OFFER: begin
                if (evt.evt_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            tag_q    <= '0;
            id_q     <= '0;
            rep_q    <= 1'b0;
            btn_held <= '0;
            drop_cnt <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            tag_q    <= tag_d;
            id_q     <= id_d;
            rep_q    <= rep_d;
            btn_held <= btn_in;
            drop_cnt <= drop_d;
        end
    end

endmodule

// File: tb/tb_button_event_ctrl.sv
module tb_button_event_ctrl;

    localparam int unsigned N_BTN  = 4;
    localparam int          DELAY  = 20;
    localparam int          PERIOD = 5;

    logic             clk;
    logic             rst;
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] btn_held;
    logic [7:0]       drop_cnt;

    button_event_ctrl_if #(.N_BTN(N_BTN)) evt_if ();

    button_event_ctrl #(
        .N_BTN        (N_BTN),
        .REPEAT_DELAY (DELAY),
        .REPEAT_PERIOD(PERIOD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_in  (btn_in),
        .evt     (evt_if),
        .btn_held(btn_held),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;

    // Behavioural model: per-button pending flags, the current offer, a hold run length
    logic [N_BTN-1:0] m_pend, m_tag, m_held;
    bit               m_off_valid;
    int               m_off_id;
    bit               m_off_rep;
    int               m_drop;
    int               m_run_len, m_run_idx;

    function automatic int lowest(input logic [N_BTN-1:0] v);
        for (int i = 0; i < int'(N_BTN); i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_tag = '0; m_held = '0;
        m_off_valid = 1'b0; m_off_id = 0; m_off_rep = 1'b0;
        m_drop = 0; m_run_len = 0; m_run_idx = 0;
    endtask

    task automatic model_step(input bit r, input logic [N_BTN-1:0] b, input bit rdy);
        logic [N_BTN-1:0] old_pend, old_tag, ev, ev_tag;
        bit acc;
        int acc_id, cur;
        if (r) begin
            model_reset();
            return;
        end
        old_pend = m_pend;
        old_tag  = m_tag;
        acc      = m_off_valid && rdy;
        acc_id   = m_off_id;
        ev       = b & ~m_held;
        ev_tag   = '0;
        cur      = lowest(b);
        if (cur < 0) m_run_len = 0;
        else if (m_run_len > 0 && cur == m_run_idx) m_run_len++;
        else begin
            m_run_len = 1;
            m_run_idx = cur;
        end
`ifdef BTN_REPEAT_EN
        // held time counted from 0 at the press edge
        if (cur >= 0 && (m_run_len - 1) >= DELAY && ((m_run_len - 1 - DELAY) % PERIOD) == 0) begin
            ev[cur]     = 1'b1;
            ev_tag[cur] = 1'b1;
        end
`endif
        if (acc) m_pend[acc_id] = 1'b0;
        for (int i = 0; i < int'(N_BTN); i++) begin
            if (ev[i]) begin
                if (old_pend[i] && !(acc && acc_id == i)) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    m_pend[i] = 1'b1;
                    m_tag[i]  = ev_tag[i];
                end
            end
        end
        if (m_off_valid) begin
            if (rdy) m_off_valid = 1'b0;
        end else if (old_pend != '0) begin
            m_off_valid = 1'b1;
            m_off_id    = lowest(old_pend);
            m_off_rep   = old_tag[m_off_id];
        end
        m_held = b;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc_n, act, exp);
        end
    endtask

    // Drive inputs, advance the model, clock once, sample 1ns after the edge
    task automatic cyc(input bit r, input logic [N_BTN-1:0] b, input bit rdy);
        rst              = r;
        btn_in           = b;
        evt_if.evt_ready = rdy;
        model_step(r, b, rdy);
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"},  int'(evt_if.evt_valid), int'(m_off_valid));
        check({tag, ".id"},     int'(evt_if.evt_id), m_off_id);
        check({tag, ".repeat"}, int'(evt_if.evt_repeat), int'(m_off_rep));
        check({tag, ".drop"},   int'(drop_cnt), m_drop);
        check({tag, ".held"},   int'(btn_held), int'(m_held));
    endtask

    typedef struct {
        bit               rst;
        logic [N_BTN-1:0] btn;
        bit               rdy;
        bit               v;
        int               id;
        bit               rep;
        int               drop;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input bit r, input logic [N_BTN-1:0] b, input bit rdy,
                           input bit v, input int id, input bit rep, input int drop);
        vec_t t;
        t.rst = r; t.btn = b; t.rdy = rdy; t.v = v; t.id = id; t.rep = rep; t.drop = drop;
        tbl.push_back(t);
    endtask

    initial begin
        rst = 1'b1;
        btn_in = '0;
        evt_if.evt_ready = 1'b0;
        model_reset();

        // reset
        add_vec(1, 4'h0, 0, 0, 0, 0, 0);
        add_vec(1, 4'h0, 0, 0, 0, 0, 0);
        // single press of btn 2, one-cycle offer
        add_vec(0, 4'h4, 1, 0, 0, 0, 0);
        add_vec(0, 4'h4, 1, 1, 2, 0, 0);
        add_vec(0, 4'h4, 1, 0, 2, 0, 0);
        add_vec(0, 4'h0, 1, 0, 2, 0, 0);
        add_vec(0, 4'h0, 1, 0, 2, 0, 0);
        // simultaneous rises on 0,1,3 -> ascending order with idle gaps
        add_vec(0, 4'hB, 1, 0, 2, 0, 0);
        add_vec(0, 4'hB, 1, 1, 0, 0, 0);
        add_vec(0, 4'hB, 1, 0, 0, 0, 0);
        add_vec(0, 4'hB, 1, 1, 1, 0, 0);
        add_vec(0, 4'hB, 1, 0, 1, 0, 0);
        add_vec(0, 4'hB, 1, 1, 3, 0, 0);
        add_vec(0, 4'hB, 1, 0, 3, 0, 0);
        add_vec(0, 4'h0, 1, 0, 3, 0, 0);
        // stalled offer of btn 1: re-press drops, lower index waits
        add_vec(0, 4'h2, 0, 0, 3, 0, 0);
        add_vec(0, 4'h0, 0, 1, 1, 0, 0);
        add_vec(0, 4'h2, 0, 1, 1, 0, 1);
        add_vec(0, 4'h3, 0, 1, 1, 0, 1);
        add_vec(0, 4'h3, 1, 0, 1, 0, 1);
        add_vec(0, 4'h3, 1, 1, 0, 0, 1);
        add_vec(0, 4'h0, 1, 0, 0, 0, 1);
        add_vec(0, 4'h0, 1, 0, 0, 0, 1);
        // rise of btn 1 on the edge it is accepted -> re-offered, no drop
        add_vec(0, 4'h2, 0, 0, 0, 0, 1);
        add_vec(0, 4'h0, 0, 1, 1, 0, 1);
        add_vec(0, 4'h2, 1, 0, 1, 0, 1);
        add_vec(0, 4'h2, 1, 1, 1, 0, 1);
        add_vec(0, 4'h0, 1, 0, 1, 0, 1);
        add_vec(0, 4'h0, 1, 0, 1, 0, 1);
        // reset mid-offer with btn 0 held -> cleared, then one btn 0 event
        add_vec(0, 4'h1, 0, 0, 1, 0, 1);
        add_vec(0, 4'h1, 0, 1, 0, 0, 1);
        add_vec(1, 4'h1, 0, 0, 0, 0, 0);
        add_vec(0, 4'h1, 0, 0, 0, 0, 0);
        add_vec(0, 4'h1, 1, 1, 0, 0, 0);
        add_vec(0, 4'h1, 1, 0, 0, 0, 0);
        add_vec(0, 4'h1, 1, 0, 0, 0, 0);
        add_vec(0, 4'h0, 1, 0, 0, 0, 0);

        foreach (tbl[k]) begin
            cyc(tbl[k].rst, tbl[k].btn, tbl[k].rdy);
            check($sformatf("vec%0d.valid", k),  int'(evt_if.evt_valid), int'(tbl[k].v));
            check($sformatf("vec%0d.id", k),     int'(evt_if.evt_id), tbl[k].id);
            check($sformatf("vec%0d.repeat", k), int'(evt_if.evt_repeat), int'(tbl[k].rep));
            check($sformatf("vec%0d.drop", k),   int'(drop_cnt), tbl[k].drop);
            check($sformatf("vec%0d.held", k),   int'(btn_held), tbl[k].rst ? 0 : int'(tbl[k].btn));
        end

        // drop counter saturation with the consumer stalled
        cyc(1, 4'h0, 0);
        for (int i = 0; i < 150; i++) begin
            cyc(0, 4'hF, 0);
            check_model("sat");
            cyc(0, 4'h0, 0);
            check_model("sat");
        end
        check("sat.final", int'(drop_cnt), 255);

`ifdef BTN_REPEAT_EN
        // hold btn 0 for 40 cycles: press event then repeats
        begin
            int off_j[$];
            bit off_r[$];
            int exp_j[5];
            bit exp_r[5];
            exp_j = '{2, 22, 27, 32, 37};
            exp_r = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
            cyc(1, 4'h0, 1);
            for (int j = 1; j <= 50; j++) begin
                cyc(0, (j <= 40) ? 4'h1 : 4'h0, 1);
                check_model("rpt");
                if (evt_if.evt_valid) begin
                    off_j.push_back(j);
                    off_r.push_back(evt_if.evt_repeat);
                end
            end
            check("rpt.count", off_j.size(), 5);
            for (int k = 0; k < 5; k++) begin
                if (k < off_j.size()) begin
                    check($sformatf("rpt.cycle%0d", k),  off_j[k], exp_j[k]);
                    check($sformatf("rpt.repeat%0d", k), int'(off_r[k]), int'(exp_r[k]));
                end
            end
        end
`endif

        // randomized traffic against the model
        cyc(1, 4'h0, 0);
        begin
            logic [N_BTN-1:0] b;
            int flip;
            b = '0;
            flip = 6;
            for (int i = 0; i < 4000; i++) begin
                if (i % 500 == 0) flip = int'($urandom_range(3, 40));
                for (int k = 0; k < int'(N_BTN); k++)
                    if ($urandom_range(flip - 1, 0) == 0) b[k] = ~b[k];
                cyc(($urandom_range(499, 0) == 0), b, ($urandom_range(2, 0) != 0));
                check_model("rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_event_ctrl.md
BUTTON_EVENT_CTRL -- requirements
Module: button_event_ctrl

Interface
REQ-001 Parameter N_BTN, default 4: number of debounced button inputs, range 2..8.
REQ-002 Parameter REPEAT_DELAY, default 50000000: held cycles before the first auto-repeat event.
REQ-003 Parameter REPEAT_PERIOD, default 10000000: cycles between later auto-repeat events.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 btn_in  input  N_BTN  debounced button levels, active-high, already synchronous to clk.
REQ-007 evt_ready  input  1  consumer accepts the offered event.
REQ-008 evt_valid  output  1  an event is offered.
REQ-009 evt_id  output  clog2(N_BTN)  index of the offered button.
REQ-010 evt_repeat  output  1  offered event came from auto-repeat, not from a press edge.
REQ-011 btn_held  output  N_BTN  registered copy of btn_in.
REQ-012 drop_cnt  output  8  saturating count of lost events.

Function
REQ-013 Edge detect: rise[i] = btn_in[i] & ~btn_held[i]; btn_held <= btn_in on every clock edge.
REQ-014 Each button has one pending bit, plus one repeat-tag bit; a rise sets pending[i] with tag 0.
REQ-015 FSM states: IDLE and OFFER; evt_valid = (state == OFFER); all outputs are registered or decoded from state.
REQ-016 IDLE -> OFFER on the first edge where any pending bit is set; evt_id latches the lowest-index pending button (fixed priority) and evt_repeat latches its tag.
REQ-017 In OFFER, evt_id and evt_repeat stay stable until acceptance, even if a lower-index button becomes pending.
REQ-018 Acceptance is an edge with evt_valid & evt_ready: pending[evt_id] clears and the FSM returns to IDLE.
REQ-019 The FSM always spends one IDLE cycle between consecutive offers.
REQ-020 Latency: a rise sampled at edge k sets pending at k; evt_valid is high after edge k+1, with no other activity.
REQ-021 Rise on a button whose pending bit is already set, with no same-edge acceptance of that button: event dropped, drop_cnt += 1, saturating at 255.
REQ-022 Rise on button i at the same edge as acceptance of button i: pending[i] stays set, tag 0, no drop counted.
REQ-023 Multiple simultaneous rises: all pending bits set; events are offered in ascending index order.
REQ-024 evt_ready while evt_valid is low is ignored.
REQ-025 Button release does not generate an event and does not cancel a pending event.

Reset
REQ-026 While rst is high at a clock edge, the block clears state: FSM = IDLE, pending = 0, tags = 0, btn_held = 0, drop_cnt = 0, repeat counter = 0.
REQ-027 Resulting output values: evt_valid = 0, evt_id = 0, evt_repeat = 0.
REQ-028 Reset mid-offer discards the offered event without acceptance.
REQ-029 A button already high when rst deasserts produces one rise event on the first non-reset edge.

Configuration
REQ-030 Macro BTN_REPEAT_EN defined: one shared repeat counter tracks the lowest-index held button.
REQ-031 Counter restart: the counter restarts from 0 whenever that index changes or no button is held.
REQ-032 First repeat: after REPEAT_DELAY consecutive held cycles, the counter sets pending[idx] with tag 1.
REQ-033 Later repeats: further repeats follow every REPEAT_PERIOD cycles while the button stays held.
REQ-034 A repeat on an already-pending button increments drop_cnt, per REQ-021.
REQ-035 Macro BTN_REPEAT_EN undefined: no counter logic is present and evt_repeat is tied to 0.

Verification
REQ-036 Press btn 2 at edge 10 with evt_ready=1 -> evt_valid high after edge 11, evt_id=2, evt_repeat=0, one-cycle pulse, pending clear.
REQ-037 Rise on btns 0,1,3 at the same edge with evt_ready=1 -> offers evt_id 0,1,3 in order, each separated by one idle cycle.
REQ-038 evt_ready=0, press btn 1, release, press again -> one offer for btn 1 held stable, drop_cnt=1.
REQ-039 Press btn 1 while btn 1 is being accepted at the same edge -> a second btn 1 event is offered next, drop_cnt unchanged.
REQ-040 rst pulse while evt_valid=1 with btn 0 held -> next cycle all outputs 0, then one btn 0 event.
REQ-041 With BTN_REPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=5, hold btn 0 for 40 cycles, evt_ready=1 -> one press event, then repeat events (evt_repeat=1) at held cycles 20, 25, 30 and 35.
